aes128_enc_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 76 +++++++
 rtl/aes_sbox.sv | 34 +++
 rtl/aes128_enc_ctrl.sv | 121 ++++++++++++
 tb/tb_aes128_enc_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the iterative AES-128 encryption controller.
//   ctrl_state_t : controller state encoding (IDLE, RUN, DONE)
//   NR           : number of AES-128 rounds
//   rcon()       : round constant for rounds 1..10
//   byte_idx()   : MSB bit position of byte S(r,c) in a 128-bit column-major block
//   xtime()      : multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
//   shift_rows() : ShiftRows over the column-major block layout
//   mix_columns(): MixColumns over the column-major block layout
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    localparam logic [3:0] NR = 4'd10;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] value;
        case (rnd)
            4'd1:    value = 8'h01;
            4'd2:    value = 8'h02;
            4'd3:    value = 8'h04;
            4'd4:    value = 8'h08;
            4'd5:    value = 8'h10;
            4'd6:    value = 8'h20;
            4'd7:    value = 8'h40;
            4'd8:    value = 8'h80;
            4'd9:    value = 8'h1b;
            4'd10:   value = 8'h36;
            default: value = 8'h00;
        endcase
        return value;
    endfunction

    function automatic int byte_idx(input int r, input int c);
        return 127 - 8 * (4 * c + r);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r is rotated left by r columns: S'(r,c) = S(r,(c+r) mod 4).
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[byte_idx(r, c) -: 8] = s[byte_idx(r, (c + r) % 4) -: 8];
            end
        end
        return t;
    endfunction

    // Each column is multiplied by the fixed polynomial {03}x^3+{01}x^2+{01}x+{02};
    // 3*a is written as xtime(a)^a.
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[byte_idx(0, c) -: 8];
            a1 = s[byte_idx(1, c) -: 8];
            a2 = s[byte_idx(2, c) -: 8];
            a3 = s[byte_idx(3, c) -: 8];
            t[byte_idx(0, c) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            t[byte_idx(1, c) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            t[byte_idx(2, c) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            t[byte_idx(3, c) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return t;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box lookup.
//   value : input byte
//   subst : substituted byte
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);

    // Table entry for input x sits at bits [2047-8x -: 8], i.e. row-major
    // from 0x00 in the top byte down to 0xff in the bottom byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always_comb begin
        subst = SBOX_TABLE[11'd2047 - {value, 3'b000} -: 8];
    end

endmodule

// File: rtl/aes128_enc_ctrl.sv
// aes128_enc_ctrl: iterative AES-128 encryption controller, one round per clock,
// with on-the-fly round key expansion.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : plaintext/key presented
//   in_ready   : controller can accept a block (IDLE)
//   plaintext  : 128-bit input block, byte 0 at [127:120], column-major
//   key        : 128-bit cipher key, same byte order
//   out_valid  : ciphertext available (DONE)
//   out_ready  : consumer accepts ciphertext
//   ciphertext : 128-bit result, held stable while out_valid is high
//   busy       : high while rounds are executing (RUN)
//   round      : current round number, 0 when idle
module aes128_enc_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic [3:0]   round
);

    ctrl_state_t  fsm;
    logic [127:0] state_reg;
    logic [127:0] rk_reg;

    logic [127:0] sub_bytes;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [127:0] rk_next;
    logic [127:0] shifted;
    logic [127:0] round_result;

    // SubBytes is byte-wise, so the 16 state S-boxes map straight onto byte lanes.
    for (genvar gi = 0; gi < 16; gi++) begin : g_state_sbox
        aes_sbox u_sbox (
            .value (state_reg[127 - 8 * gi -: 8]),
            .subst (sub_bytes[127 - 8 * gi -: 8])
        );
    end

    // SubWord(RotWord(w3)) for the key schedule; w3 is the last column of rk_reg.
    assign rot_word = {rk_reg[23:0], rk_reg[31:24]};

    for (genvar gk = 0; gk < 4; gk++) begin : g_key_sbox
        aes_sbox u_sbox (
            .value (rot_word[31 - 8 * gk -: 8]),
            .subst (sub_word[31 - 8 * gk -: 8])
        );
    end

    // Next round key and round output; the final round skips MixColumns.
    always_comb begin
        rk_next[127:96] = rk_reg[127:96] ^ sub_word ^ {rcon(round), 24'h000000};
        rk_next[95:64]  = rk_reg[95:64] ^ rk_next[127:96];
        rk_next[63:32]  = rk_reg[63:32] ^ rk_next[95:64];
        rk_next[31:0]   = rk_reg[31:0]  ^ rk_next[63:32];
        shifted         = shift_rows(sub_bytes);
        if (round == NR) begin
            round_result = shifted ^ rk_next;
        end else begin
            round_result = mix_columns(shifted) ^ rk_next;
        end
    end

    // Controller FSM; owns the AES state, round key, round counter and result.
    // Inputs are only sampled on the accept edge in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= IDLE;
            state_reg  <= '0;
            rk_reg     <= '0;
            round      <= 4'd0;
            ciphertext <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= plaintext ^ key;
                        rk_reg    <= key;
                        round     <= 4'd1;
                        fsm       <= RUN;
                    end
                end
                RUN: begin
                    state_reg <= round_result;
                    rk_reg    <= rk_next;
                    round     <= round + 4'd1;
                    if (round == NR) begin
                        ciphertext <= round_result;
                        fsm        <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        round <= 4'd0;
                        fsm   <= IDLE;
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status flags decode the state register only.
    always_comb begin
        in_ready  = (fsm == IDLE);
        out_valid = (fsm == DONE);
        busy      = (fsm == RUN);
    end

endmodule

// File: tb/tb_aes128_enc_ctrl.sv
// tb_aes128_enc_ctrl: self-checking bench for aes128_enc_ctrl using FIPS-197
// vectors plus random blocks checked against a byte-array AES reference model.
module tb_aes128_enc_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] ciphertext;
    logic         busy;
    logic [3:0]   round;

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0] sboxTab [256];

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes128_enc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy),
        .round      (round)
    );

    always #5 clk = ~clk;

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        logic [15:0] d;
        d = {v, v} << k;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse (x^254) then affine map.
    function automatic logic [7:0] sboxDef(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // Full AES-128 encryption on a 4x4 byte matrix with a precomputed key schedule.
    function automatic logic [127:0] aesModel(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   st  [4][4];
        logic [7:0]   tmp [4][4];
        logic [31:0]  w   [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = pt[127 - 8 * (4 * c + r) -: 8] ^ w[c][31 - 8 * r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    tmp[r][c] = sboxTab[st[r][(c + r) % 4]];
            for (int c = 0; c < 4; c++) begin
                a0 = tmp[0][c]; a1 = tmp[1][c]; a2 = tmp[2][c]; a3 = tmp[3][c];
                if (rnd < 10) begin
                    st[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    st[0][c] = a0; st[1][c] = a1; st[2][c] = a2; st[3][c] = a3;
                end
                for (int r = 0; r < 4; r++)
                    st[r][c] = st[r][c] ^ w[4 * rnd + c][31 - 8 * r -: 8];
            end
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8 * (4 * c + r) -: 8] = st[r][c];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Called at a negedge in IDLE: present a block and let the next edge accept it.
    task automatic applyStimulus(input string tag, input logic [127:0] pt, input logic [127:0] k, input bit holdValid);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        checkOutput({tag, " in_ready before accept"}, 128'(in_ready), 128'(1));
        @(negedge clk);
        if (!holdValid) in_valid = 1'b0;
    endtask

    // Checks the RUN cycles numbered first..last, one negedge each.
    task automatic checkRunWindow(input string tag, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            checkOutput({tag, " round"}, 128'(round), 128'(i));
            checkOutput({tag, " busy in run"}, 128'(busy), 128'(1));
            checkOutput({tag, " out_valid in run"}, 128'(out_valid), 128'(0));
            checkOutput({tag, " in_ready in run"}, 128'(in_ready), 128'(0));
            @(negedge clk);
        end
    endtask

    // First DONE cycle onwards: out_ready stays low for holdCycles cycles, then handshakes.
    task automatic awaitResult(input string tag, input logic [127:0] exp, input int holdCycles);
        for (int k = 0; k <= holdCycles; k++) begin
            checkOutput({tag, " out_valid"}, 128'(out_valid), 128'(1));
            checkOutput({tag, " ciphertext"}, ciphertext, exp);
            checkOutput({tag, " in_ready in done"}, 128'(in_ready), 128'(0));
            checkOutput({tag, " busy in done"}, 128'(busy), 128'(0));
            out_ready = (k == holdCycles);
            @(negedge clk);
        end
        out_ready = 1'b0;
        checkOutput({tag, " out_valid after handshake"}, 128'(out_valid), 128'(0));
        checkOutput({tag, " in_ready after handshake"}, 128'(in_ready), 128'(1));
        checkOutput({tag, " round idle"}, 128'(round), 128'(0));
        checkOutput({tag, " busy idle"}, 128'(busy), 128'(0));
    endtask

    initial begin
        logic [127:0] rpt, rkey;
        int hold;

        for (int i = 0; i < 256; i++) sboxTab[i] = sboxDef(8'(i));

        // Reset values while rst_n is held low.
        #2;
        checkOutput("reset in_ready", 128'(in_ready), 128'(1));
        checkOutput("reset out_valid", 128'(out_valid), 128'(0));
        checkOutput("reset busy", 128'(busy), 128'(0));
        checkOutput("reset round", 128'(round), 128'(0));
        checkOutput("reset ciphertext", ciphertext, 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // App. B with out_ready already high: out_valid 10 cycles after accept.
        $display("[TB] FIPS-197 App. B");
        out_ready = 1'b1;
        applyStimulus("appB", PT_B, KEY_B, 1'b0);
        checkRunWindow("appB", 1, 10);
        awaitResult("appB", CT_B, 0);

        // App. C with 5 cycles of backpressure; exactly one handshake.
        $display("[TB] FIPS-197 App. C.1 with backpressure");
        applyStimulus("appC", PT_C, KEY_C, 1'b0);
        checkRunWindow("appC", 1, 10);
        awaitResult("appC", CT_C, 5);
        @(negedge clk);
        checkOutput("appC single handshake", 128'(out_valid), 128'(0));

        // Back-to-back with in_valid held high throughout.
        $display("[TB] back-to-back");
        applyStimulus("b2b A", PT_B, KEY_B, 1'b1);
        plaintext = PT_C;
        key       = KEY_C;
        checkRunWindow("b2b A", 1, 10);
        awaitResult("b2b A", CT_B, 0);
        @(negedge clk);
        in_valid = 1'b0;
        checkRunWindow("b2b C", 1, 10);
        awaitResult("b2b C", CT_C, 0);

        // Input corruption and an in_valid pulse during RUN are ignored.
        $display("[TB] input corruption during run");
        applyStimulus("corrupt", PT_C, KEY_C, 1'b0);
        checkRunWindow("corrupt", 1, 2);
        plaintext = rand128();
        key       = rand128();
        in_valid  = 1'b1;
        checkRunWindow("corrupt", 3, 3);
        in_valid  = 1'b0;
        checkRunWindow("corrupt", 4, 10);
        awaitResult("corrupt", CT_C, 2);

        // Asynchronous reset at round 5 discards the block.
        $display("[TB] reset mid-run");
        applyStimulus("midreset", PT_B, KEY_B, 1'b0);
        checkRunWindow("midreset", 1, 4);
        checkOutput("midreset at round 5", 128'(round), 128'(5));
        rst_n = 1'b0;
        #1;
        checkOutput("midreset in_ready", 128'(in_ready), 128'(1));
        checkOutput("midreset out_valid", 128'(out_valid), 128'(0));
        checkOutput("midreset busy", 128'(busy), 128'(0));
        checkOutput("midreset round", 128'(round), 128'(0));
        checkOutput("midreset ciphertext", ciphertext, 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checkOutput("midreset no out_valid", 128'(out_valid), 128'(0));
            @(negedge clk);
        end
        applyStimulus("appB rerun", PT_B, KEY_B, 1'b0);
        checkRunWindow("appB rerun", 1, 10);
        awaitResult("appB rerun", CT_B, 1);

        // Random blocks against the reference model.
        $display("[TB] random blocks");
        for (int n = 0; n < 6; n++) begin
            rpt  = rand128();
            rkey = rand128();
            hold = int'($urandom_range(0, 3));
            applyStimulus("random", rpt, rkey, 1'b0);
            checkRunWindow("random", 1, 10);
            awaitResult("random", aesModel(rpt, rkey), hold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
